// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the 8-bit ALU core and its result buffer.
//   - opcode encodings (ADD .. PASS_B)
//   - datapath and opcode widths
//   - bit positions of the flag nibble {neg, zero, borrow, carry}
//   - buffered entry layout (17 bits) and a flag derivation helper
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int OP_W    = 5;
    localparam int FLAGS_W = 4;
    localparam int ENTRY_W = OP_W + ALU_W + FLAGS_W;  // 17

    localparam int FLAG_C = 0;
    localparam int FLAG_B = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    localparam logic [OP_W-1:0] ADD    = 5'b00000;
    localparam logic [OP_W-1:0] ADC    = 5'b00001;
    localparam logic [OP_W-1:0] SUB    = 5'b00010;
    localparam logic [OP_W-1:0] SBB    = 5'b00011;
    localparam logic [OP_W-1:0] INC    = 5'b00100;
    localparam logic [OP_W-1:0] DEC    = 5'b00101;
    localparam logic [OP_W-1:0] AND    = 5'b00110;
    localparam logic [OP_W-1:0] OR     = 5'b00111;
    localparam logic [OP_W-1:0] XOR    = 5'b01000;
    localparam logic [OP_W-1:0] NOT    = 5'b01001;
    localparam logic [OP_W-1:0] NAND   = 5'b01010;
    localparam logic [OP_W-1:0] NOR    = 5'b01011;
    localparam logic [OP_W-1:0] XNOR   = 5'b01100;
    localparam logic [OP_W-1:0] SHL    = 5'b01101;
    localparam logic [OP_W-1:0] SHR    = 5'b01110;
    localparam logic [OP_W-1:0] SAR    = 5'b01111;
    localparam logic [OP_W-1:0] ROL    = 5'b10000;
    localparam logic [OP_W-1:0] ROR    = 5'b10001;
    localparam logic [OP_W-1:0] PASS_A = 5'b10010;
    localparam logic [OP_W-1:0] PASS_B = 5'b10011;

    // Field order puts the opcode in the MSBs and the flag nibble in the LSBs.
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [ALU_W-1:0]   result;
        logic [FLAGS_W-1:0] flags;
    } entry_t;

    function automatic logic [FLAGS_W-1:0] derive_flags(
        input logic [ALU_W-1:0] result,
        input logic             borrow,
        input logic             carry
    );
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_N] = result[ALU_W-1];
        f[FLAG_Z] = (result == '0);
        f[FLAG_B] = borrow;
        f[FLAG_C] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: producer and consumer handshakes of the result buffer.
//   in_*  : ALU side (valid/ready, result, carry, borrow, opcode)
//   out_* : consumer side (valid/ready, result, opcode, flags)
// Modports: slave = the buffer, master = whoever drives the ALU results and
// consumes the buffered entries.
interface alu_result_buffer_if;
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ALU_W-1:0]   in_result;
    logic               in_carry;
    logic               in_borrow;
    logic [OP_W-1:0]    in_op;

    logic               out_valid;
    logic               out_ready;
    logic [ALU_W-1:0]   out_result;
    logic [OP_W-1:0]    out_op;
    logic [FLAGS_W-1:0] out_flags;

    modport slave (
        input  in_valid, in_result, in_carry, in_borrow, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_flags
    );

    modport master (
        output in_valid, in_result, in_carry, in_borrow, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_flags
    );
endinterface

// File: rtl/alu_rbuf_fifo.sv
// alu_rbuf_fifo: generic first-word fall-through FIFO, DEPTH x WIDTH.
//   clk, rst_n : clock, asynchronous active-low reset (storage not reset)
//   push_i     : write wdata_i (ignored while full)
//   pop_i      : drop head entry (ignored while empty)
//   wdata_i    : entry to write
//   rdata_o    : entry at the read pointer, valid whenever !empty_o
//   count_o    : occupancy, 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module alu_rbuf_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Fall-through read: head is visible as soon as it is written. When empty
    // this shows whichever stale slot the read pointer sits on.
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: captures ALU results, derives zero/negative flags and
// queues {op, result, flags} for the writeback/bus consumer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : in_* producer handshake, out_* consumer handshake
//   count           : current occupancy, 0..DEPTH
//   clr_status      : one-cycle pulse clearing the sticky bits (and stats)
//   status_carry    : sticky, set by any accepted entry with carry
//   status_borrow   : sticky, set by any accepted entry with borrow
// Optional macro ALU_RESULT_BUF_STATS_EN adds:
//   stat_pushes      : saturating count of accepted entries
//   stat_full_cycles : saturating count of cycles with in_valid && !in_ready
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_result_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clr_status,
    output logic                   status_carry,
    output logic                   status_borrow
`ifdef ALU_RESULT_BUF_STATS_EN
    ,
    output logic [15:0]            stat_pushes,
    output logic [15:0]            stat_full_cycles
`endif
);
    entry_t wr_entry, rd_entry;
    logic   full, empty;
    logic   push, pop;
    logic   status_carry_q, status_carry_d;
    logic   status_borrow_q, status_borrow_d;

    // Handshakes come straight from registered occupancy; a same-cycle pop
    // never frees a slot for a push (no bypass).
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && !full;
    assign pop           = bus.out_ready && !empty;

    always_comb begin
        wr_entry        = '0;
        wr_entry.op     = bus.in_op;
        wr_entry.result = bus.in_result;
        wr_entry.flags  = derive_flags(bus.in_result, bus.in_borrow, bus.in_carry);
    end

    alu_rbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.out_op     = rd_entry.op;
    assign bus.out_result = rd_entry.result;
    assign bus.out_flags  = rd_entry.flags;

    // Clear first, then set, so a coinciding setting push survives clr_status.
    always_comb begin
        status_carry_d  = status_carry_q;
        status_borrow_d = status_borrow_q;
        if (clr_status) begin
            status_carry_d  = 1'b0;
            status_borrow_d = 1'b0;
        end
        if (push && bus.in_carry)  status_carry_d  = 1'b1;
        if (push && bus.in_borrow) status_borrow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_carry_q  <= 1'b0;
            status_borrow_q <= 1'b0;
        end else begin
            status_carry_q  <= status_carry_d;
            status_borrow_q <= status_borrow_d;
        end
    end

    assign status_carry  = status_carry_q;
    assign status_borrow = status_borrow_q;

`ifdef ALU_RESULT_BUF_STATS_EN
    logic [15:0] stat_pushes_q, stat_pushes_d;
    logic [15:0] stat_full_q, stat_full_d;

    // clr_status wins over a same-cycle event: counters restart from zero.
    always_comb begin
        stat_pushes_d = stat_pushes_q;
        stat_full_d   = stat_full_q;
        if (clr_status) begin
            stat_pushes_d = '0;
            stat_full_d   = '0;
        end else begin
            if (push && (stat_pushes_q != 16'hFFFF))
                stat_pushes_d = stat_pushes_q + 16'd1;
            if (bus.in_valid && full && (stat_full_q != 16'hFFFF))
                stat_full_d = stat_full_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pushes_q <= '0;
            stat_full_q   <= '0;
        end else begin
            stat_pushes_q <= stat_pushes_d;
            stat_full_q   <= stat_full_d;
        end
    end

    assign stat_pushes      = stat_pushes_q;
    assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       clr_status;
    logic [3:0] count;
    logic       status_carry;
    logic       status_borrow;
`ifdef ALU_RESULT_BUF_STATS_EN
    logic [15:0] stat_pushes;
    logic [15:0] stat_full_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference state.
    logic [16:0] exp_q[$];
    logic        m_carry;
    logic        m_borrow;

    alu_result_buffer_if bus ();

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .count         (count),
        .clr_status    (clr_status),
        .status_carry  (status_carry),
        .status_borrow (status_borrow)
`ifdef ALU_RESULT_BUF_STATS_EN
        ,
        .stat_pushes      (stat_pushes),
        .stat_full_cycles (stat_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] res, input logic [4:0] op,
                         input logic c, input logic b, input logic rdy);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_op     = op;
        bus.in_carry  = c;
        bus.in_borrow = b;
        bus.out_ready = rdy;
    endtask

    // One clock: score any pop against the queue head, record any accepted
    // push, advance, then compare occupancy/handshake/sticky state.
    task automatic cycle();
        logic [16:0] expe;
        logic        acc;
        logic [7:0]  r;
        acc = bus.in_valid && (exp_q.size() != DEPTH);
        if (bus.out_ready && exp_q.size() != 0) begin
            expe = exp_q.pop_front();
            check("head", {15'd0, bus.out_op, bus.out_result, bus.out_flags}, {15'd0, expe});
            $display("pop  op=%0h result=%02h flags=%04b", bus.out_op, bus.out_result, bus.out_flags);
        end
        if (clr_status) begin
            m_carry  = 1'b0;
            m_borrow = 1'b0;
        end
        if (acc) begin
            r = bus.in_result;
            exp_q.push_back({bus.in_op, r, r[7], (r == 8'h00), bus.in_borrow, bus.in_carry});
            if (bus.in_carry)  m_carry  = 1'b1;
            if (bus.in_borrow) m_borrow = 1'b1;
            $display("push op=%0h result=%02h c=%0b b=%0b", bus.in_op, r, bus.in_carry, bus.in_borrow);
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
        check("status_carry", 32'(status_carry), 32'(m_carry));
        check("status_borrow", 32'(status_borrow), 32'(m_borrow));
    endtask

    initial begin
        rst_n      = 1'b0;
        clr_status = 1'b0;
        m_carry    = 1'b0;
        m_borrow   = 1'b0;
        drive(1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_status", {30'd0, status_borrow, status_carry}, 32'd0);

        // ADD result 0 with carry
        drive(1'b1, 8'h00, ADD, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b0);
        check("add_out_valid", 32'(bus.out_valid), 32'd1);
        check("add_out_result", 32'(bus.out_result), 32'h00);
        check("add_out_flags", 32'(bus.out_flags), 32'b0101);
        check("add_out_op", 32'(bus.out_op), 32'(5'b00000));
        check("add_status_carry", 32'(status_carry), 32'd1);
        drive(1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b1);
        cycle();

        // Fill to full, refuse a 9th, drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 8'(i), SUB, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 8'h09, SUB, 1'b0, 1'b0, 1'b0);
        cycle();
        check("ninth_refused", 32'(count), 32'd8);
        drive(1'b0, 8'h00, SUB, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle();
        check("drained_count", 32'(count), 32'd0);
        check("drained_out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming push+pop with pointer wrap
        drive(1'b1, 8'h80, XOR, 1'b0, 1'b0, 1'b1);
        cycle();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 8'(8'h80 + i), XOR, 1'b0, 1'b0, 1'b1);
            check("stream_neg", 32'(bus.out_flags[FLAG_N]), 32'd1);
            cycle();
            check("stream_count", 32'(count), 32'd1);
        end
        drive(1'b0, 8'h00, XOR, 1'b0, 1'b0, 1'b1);
        cycle();

        // Full with simultaneous pop: push refused, then accepted next cycle
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'hA0 + i), ROL, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'hAA, ROR, 1'b0, 1'b0, 1'b1);
        cycle();
        check("nobypass_count", 32'(count), 32'd7);
        drive(1'b1, 8'hAA, ROR, 1'b0, 1'b0, 1'b0);
        cycle();
        check("after_nobypass_count", 32'(count), 32'd8);
        drive(1'b0, 8'h00, ROR, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle();

        // Sticky: set beats clear, then clear alone
        drive(1'b1, 8'h7F, SBB, 1'b0, 1'b1, 1'b1);
        clr_status = 1'b1;
        cycle();
        check("sticky_set_wins", 32'(status_borrow), 32'd1);
        drive(1'b0, 8'h00, SBB, 1'b0, 1'b0, 1'b1);
        cycle();
        clr_status = 1'b1;
        cycle();
        clr_status = 1'b0;
        check("sticky_cleared", 32'(status_borrow), 32'd0);
        check("sticky_carry_cleared", 32'(status_carry), 32'd0);

        // Asynchronous reset with five entries queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h10 + i), ADC, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check("pre_reset_count", 32'(count), 32'd5);
        drive(1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("async_rst_status_carry", 32'(status_carry), 32'd0);
`ifdef ALU_RESULT_BUF_STATS_EN
        check("async_rst_stat_pushes", 32'(stat_pushes), 32'd0);
`endif
        $display("reset asserted with 5 entries queued");
        exp_q.delete();
        m_carry  = 1'b0;
        m_borrow = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b1);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the 8-bit ALU core. Captures each ALU result, with its carry/borrow flags and the opcode that produced it, under a valid/ready handshake. Derives zero and negative flags and buffers entries in a small FIFO for the consumer (writeback/bus interface). Also keeps sticky carry/borrow status bits for software polling.

## Interface
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU result presented this cycle
- in_ready  output  1  buffer can accept an entry
- in_result  input  8  ALU result
- in_carry  input  1  ALU carry_out
- in_borrow  input  1  ALU borrow_out
- in_op  input  5  ALU opcode that produced the result
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head entry
- out_result  output  8  head result
- out_op  output  5  head opcode
- out_flags  output  4  head flags {neg, zero, borrow, carry}
- count  output  $clog2(DEPTH)+1  current occupancy
- clr_status  input  1  one-cycle pulse, clears sticky bits
- status_carry  output  1  sticky: any accepted entry had carry
- status_borrow  output  1  sticky: any accepted entry had borrow

## Operation
- Push when in_valid && in_ready. Stored entry = {in_op, in_result, neg=in_result[7], zero=(in_result==0), in_borrow, in_carry}, 17 bits.
- Pop when out_valid && out_ready.
- in_ready = (count != DEPTH). There is no bypass: when full, in_ready stays low even if a pop happens in the same cycle.
- out_valid = (count != 0). out_* always show the entry at the read pointer (first-word fall-through). out_* are undefined-but-stable when empty; the RTL drives the stale slot.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Sticky bits: set on a push whose carry (or borrow) is 1. clr_status clears both. If clr_status and a setting push coincide, set wins.
- in_op is stored opaquely. No opcode-dependent behaviour.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, out_valid=0, in_ready=1, status_carry=0, status_borrow=0. Storage is not reset.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle).
- in_ready and out_valid depend only on registered count. No combinational in-to-out path.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset asserted mid-operation discards all entries immediately. Sticky bits clear.

## Configuration
- ALU_RESULT_BUF_STATS_EN defined: adds outputs stat_pushes (16 bits, accepted entries) and stat_full_cycles (16 bits, cycles with in_valid && !in_ready).
  - Both counters saturate at 16'hFFFF.
  - Both clear on reset and on clr_status.
- ALU_RESULT_BUF_STATS_EN undefined: those ports and counters do not exist.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (ADD=5'b00000 through PASS_B=5'b10011)
  - ALU_W=8, OP_W=5
  - flag bit indices (FLAG_C=0, FLAG_B=1, FLAG_Z=2, FLAG_N=3)
  - entry width ENTRY_W=17
- One sub-module, alu_rbuf_fifo: generic DEPTH×ENTRY_W storage, pointers, count, full/empty.
- The top level adds flag derivation, the sticky status bits and the stats counters.

## Test plan
- Reset, then push ADD result 8'h00, carry=1 -> next cycle out_valid=1, out_result=8'h00, out_flags=4'b0101, out_op=5'b00000, status_carry=1.
- With out_ready=0, push 8 entries 8'h01..8'h08 -> count=8 and in_ready=0. Then a 9th in_valid is not accepted. Then drain with out_ready=1 -> outputs 01..08 in order, count reaches 0, out_valid=0.
- Continuous push and pop for 20 cycles with values 8'h80+i -> count stays 1, each out_flags[3]=1, pointer wrap is seamless and values arrive in order.
- Full buffer, out_ready=1 and in_valid=1 in the same cycle -> pop occurs, push is refused, count=7. The next cycle accepts the push.
- Push with borrow=1 in the same cycle as clr_status=1 -> status_borrow=1 afterwards. A clr_status alone next cycle -> status_borrow=0.
- Assert rst_n=0 asynchronously with count=5 -> count=0, out_valid=0 and in_ready=1 before the next clk edge. With ALU_RESULT_BUF_STATS_EN defined, stat_pushes=0.
